// File: rtl/mul_add.sv
// mul_add: sequential compose unit computing result = Q*B + R by iterative
// shift-and-add. One multiplier bit is consumed per CALC cycle, so the
// latency is fixed regardless of operand values. A small control FSM
// (IDLE/CALC/DONE) sequences the datapath through the start/done handshake.
module mul_add #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    // Counter must be able to hold 0..WIDTH.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               overflow_reg;

    logic [2*WIDTH-1:0] acc_next;
    logic               accept;
    logic               last_step;

    // A start is honoured only when no calculation is in flight.
    assign accept    = start && (state_reg != CALC);
    assign last_step = (state_reg == CALC) && (cnt_reg == LAST_CNT);

    // Conditional partial-product add for the current multiplier bit.
    // The accumulator is double width, so this sum cannot wrap.
    always_comb begin
        acc_next = acc_reg;
        if (mplier_reg[0]) begin
            acc_next = acc_reg + mcand_reg;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: load on accepted start, leave CALC after WIDTH steps.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = CALC;
            end
            CALC: begin
                if (last_step) state_next = DONE;
            end
            DONE: begin
                if (accept) state_next = CALC;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-and-add iteration, counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else if (accept) begin
            acc_reg    <= {{WIDTH{1'b0}}, R};
            mcand_reg  <= {{WIDTH{1'b0}}, B};
            mplier_reg <= Q;
            cnt_reg    <= '0;
        end else if (state_reg == CALC) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
        end
    end

    // Result capture on the final step, including that step's add; held
    // until the next operation completes or reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_reg   <= '0;
            overflow_reg <= 1'b0;
        end else if (last_step) begin
            result_reg   <= acc_next[WIDTH-1:0];
            overflow_reg <= |acc_next[2*WIDTH-1:WIDTH];
        end
    end

    assign result   = result_reg;
    assign overflow = overflow_reg;
    assign busy     = (state_reg == CALC);
    assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_mul_add.sv
// tb_mul_add: directed and randomized checks of mul_add against a plain
// 64-bit arithmetic model of Q*B+R.
module tb_mul_add;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    mul_add #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .Q        (Q),
        .B        (B),
        .R        (R),
        .result   (result),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; sample/drive 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for exactly one edge.
    task automatic start_op(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] r);
        Q = q; B = b; R = r; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for done; edges counts from the accepting edge as 1.
    task automatic wait_done(input int e0, output int edges, output int bcnt, output int viol);
        edges = e0;
        bcnt  = busy ? 1 : 0;
        viol  = 0;
        while (done !== 1'b1 && edges < LAT + 40) begin
            tick();
            edges++;
            if (busy === 1'b1) bcnt++;
            if (busy === 1'b1 && done === 1'b1) viol++;
        end
    endtask

    // Full operation with model comparison.
    task automatic run_check(input string tag, input logic [WIDTH-1:0] q,
                             input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] r);
        logic [63:0] full;
        int edges, bcnt, viol;
        full = 64'(q) * 64'(b) + 64'(r);
        start_op(q, b, r);
        wait_done(1, edges, bcnt, viol);
        check({tag, " latency"}, 64'(edges), 64'(LAT));
        check({tag, " busy_cycles"}, 64'(bcnt), 64'(WIDTH));
        check({tag, " busy_done_excl"}, 64'(viol), 64'd0);
        check({tag, " result"}, 64'(result), {32'd0, full[31:0]});
        check({tag, " overflow"}, 64'(overflow), 64'(full[63:32] != 32'd0));
    endtask

    initial begin
        int edges, bcnt, viol;
        logic [WIDTH-1:0] a, b, q, r;

        reset = 1'b1; start = 1'b0; Q = '0; B = '0; R = '0;
        tick(); tick();
        check("reset result", 64'(result), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();
        check("idle done", 64'(done), 64'd0);

        // Basic, then hold with start low.
        run_check("basic", 32'd7, 32'd5, 32'd3);
        check("basic value", 64'(result), 64'd38);
        for (int i = 0; i < 5; i++) tick();
        check("basic hold done", 64'(done), 64'd1);
        check("basic hold result", 64'(result), 64'd38);
        check("basic hold busy", 64'(busy), 64'd0);

        run_check("zero_q", 32'd0, 32'hFFFF_FFFF, 32'h1234);
        run_check("zero_b", 32'h1234_5678, 32'd0, 32'hABCD);
        run_check("prod_ovf", 32'h0001_0000, 32'h0001_0000, 32'd0);
        check("prod_ovf flag", 64'(overflow), 64'd1);
        run_check("carry_ovf", 32'd1, 32'hFFFF_FFFF, 32'd1);
        check("carry_ovf flag", 64'(overflow), 64'd1);
        run_check("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Start during CALC is ignored.
        start_op(32'd3, 32'd4, 32'd0);
        for (int i = 0; i < 9; i++) tick();
        Q = 32'd9; B = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        check("ignored busy", 64'(busy), 64'd1);
        wait_done(11, edges, bcnt, viol);
        check("ignored latency", 64'(edges), 64'(LAT));
        check("ignored result", 64'(result), 64'd12);

        // Restart from DONE.
        start_op(32'd9, 32'd9, 32'd1);
        check("restart done low", 64'(done), 64'd0);
        check("restart busy high", 64'(busy), 64'd1);
        wait_done(1, edges, bcnt, viol);
        check("restart latency", 64'(edges), 64'(LAT));
        check("restart result", 64'(result), 64'd82);

        // Asynchronous reset mid-calculation.
        start_op(32'd100, 32'd200, 32'd5);
        for (int i = 0; i < 14; i++) tick();
        check("midreset pre busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset result", 64'(result), 64'd0);
        check("midreset overflow", 64'(overflow), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        check("postreset done", 64'(done), 64'd0);
        run_check("postreset", 32'd2, 32'd3, 32'd1);
        check("postreset value", 64'(result), 64'd7);

        // Random general operands.
        for (int i = 0; i < 20; i++) begin
            q = $urandom; b = $urandom; r = $urandom;
            if (i % 4 == 0) q = q >> 16;
            if (i % 4 == 1) b = b >> 20;
            run_check("rand", q, b, r);
        end

        // Round trip: divide A by B in the model, recompose in the DUT.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
            if (b == 0) b = 32'd1;
            q = a / b;
            r = a % b;
            run_check("roundtrip", q, b, r);
            check("roundtrip equals A", 64'(result), 64'(a));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
